pc_fetch_unit: RTL and testbench

//  Instruction-fetch stage of the 16-bit core: owns the program counter, issues
//  req/ack fetches to instruction memory, hands {instr, pc} to decode on a

---
 rtl/pc_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction-fetch stage of the 16-bit core. Owns the program counter, issues
// req/ack fetches to instruction memory and hands {instr, pc} to decode over a
// valid/ready handshake. if_pc feeds the PC input of the branch-target adder,
// whose PCPlusImm result comes back here as the taken-branch target.
//
// Parameters
//   RESET_VECTOR  PC loaded on reset; address of the first fetch
//   PC_STEP       sequential PC increment (word-addressed memory)
//
// Ports
//   clk           single clock, all state updates on the rising edge
//   reset_n       synchronous, active-low reset
//   imem_addr     fetch address (always the internal pc)
//   imem_req      fetch request, held until imem_ack
//   imem_ack      memory response, imem_rdata valid in the same cycle
//   imem_rdata    fetched instruction word
//   if_pc         PC of if_instr
//   if_instr      instruction presented to decode
//   if_valid      if_instr / if_pc valid
//   id_ready      decode accepts when if_valid & id_ready
//   branch_taken  redirect to PCPlusImm this cycle
//   PCPlusImm     branch target from the adder
//   jump_en       redirect to jump_target (wins over branch_taken)
//   jump_target   absolute jump address
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] PC_STEP      = 16'd1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] if_pc,
  output logic [15:0] if_instr,
  output logic        if_valid,
  input  logic        id_ready,
  input  logic        branch_taken,
  input  logic [15:0] PCPlusImm,
  input  logic        jump_en,
  input  logic [15:0] jump_target
);

  // IDLE    : no request on the bus; always moves to REQ next cycle
  // REQ     : request outstanding at pc; its data will be captured
  // VALID   : captured instruction presented to decode
  // DISCARD : request outstanding whose data must be thrown away because the
  //           PC was redirected after the request had already been issued
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    VALID   = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] pc;
  logic [15:0] pc_nxt;
  logic [15:0] instr_p0;
  logic [15:0] instr_p0_nxt;
  logic [15:0] pc_p0;
  logic [15:0] pc_p0_nxt;
  logic        vld_p0;

  logic        redirect;
  logic [15:0] target;

  // Sequential PC advance; the sum wraps modulo 2^16 with no carry kept.
  function automatic logic [15:0] pc_step(input logic [15:0] cur);
    return cur + PC_STEP;
  endfunction

  assign redirect = jump_en | branch_taken;
  assign target   = jump_en ? jump_target : PCPlusImm;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_p0_nxt = instr_p0;
    pc_p0_nxt    = pc_p0;

    case (state)
      IDLE: begin
        // Any ack seen here belongs to a request killed by reset; ignore it.
        state_nxt = REQ;
        if (redirect) begin
          pc_nxt = target;
        end
      end

      REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            // Data arrived but the stream is being redirected: drop it and
            // start a fresh request at the target right away.
            pc_nxt    = target;
            state_nxt = REQ;
          end else begin
            instr_p0_nxt = imem_rdata;
            pc_p0_nxt    = pc;
            pc_nxt       = pc_step(pc);
            state_nxt    = VALID;
          end
        end else if (redirect) begin
          // The old request is still in flight and must finish before a new
          // address can be issued.
          pc_nxt    = target;
          state_nxt = DISCARD;
        end
      end

      VALID: begin
        if (redirect) begin
          // Squash the presented instruction even if decode takes it now.
          pc_nxt    = target;
          state_nxt = REQ;
        end else if (id_ready) begin
          state_nxt = REQ;
        end
      end

      DISCARD: begin
        // Later redirects overwrite earlier ones.
        if (redirect) begin
          pc_nxt = target;
        end
        if (imem_ack) begin
          state_nxt = REQ;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= RESET_VECTOR;
      instr_p0 <= '0;
      pc_p0    <= RESET_VECTOR;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      instr_p0 <= instr_p0_nxt;
      pc_p0    <= pc_p0_nxt;
    end
  end

  // Decode-facing stage boundary
  assign vld_p0    = (state == VALID);
  assign if_valid  = vld_p0;
  assign if_instr  = instr_p0;
  assign if_pc     = pc_p0;

  assign imem_req  = (state == REQ) || (state == DISCARD);
  assign imem_addr = pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] if_pc;
  logic [15:0] if_instr;
  logic        if_valid;
  logic        id_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] PCPlusImm = 16'h0000;
  logic        jump_en = 1'b0;
  logic [15:0] jump_target = 16'h0000;

  // second instance with RESET_VECTOR at the top of the address space
  logic        w_rst_n = 1'b0;
  logic [15:0] w_addr;
  logic        w_req;
  logic        w_ack = 1'b0;
  logic [15:0] w_rdata = 16'h0000;
  logic [15:0] w_pc;
  logic [15:0] w_instr;
  logic        w_valid;
  logic        w_idr = 1'b1;
  logic        z_bit = 1'b0;
  logic [15:0] z_word = 16'h0000;

  pc_fetch_unit u_dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_pc(if_pc),
    .if_instr(if_instr), .if_valid(if_valid), .id_ready(id_ready),
    .branch_taken(branch_taken), .PCPlusImm(PCPlusImm), .jump_en(jump_en),
    .jump_target(jump_target)
  );

  pc_fetch_unit #(.RESET_VECTOR(16'hFFFF), .PC_STEP(16'd1)) u_wrap (
    .clk(clk), .reset_n(w_rst_n), .imem_addr(w_addr), .imem_req(w_req),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .if_pc(w_pc),
    .if_instr(w_instr), .if_valid(w_valid), .id_ready(w_idr),
    .branch_taken(z_bit), .PCPlusImm(z_word), .jump_en(z_bit),
    .jump_target(z_word)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // memory responder state
  int lat = 0;
  int age = 0;
  bit rnd = 1'b0;
  logic [15:0] req_addr = 16'h0000;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and drive the memory responses.
  // The memory answers with the word at the address seen when the request
  // started, so data of a redirected request is distinguishable.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rnd) begin
      imem_ack   = imem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 31) == 0);
      imem_rdata = 16'($urandom);
    end else if (imem_req) begin
      if (age == 0) req_addr = imem_addr;
      imem_ack   = (age >= lat);
      imem_rdata = imem_ack ? mem_word(req_addr) : 16'h0000;
      age        = imem_ack ? 0 : age + 1;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 16'h0000;
      age        = 0;
    end
    w_ack   = w_req;
    w_rdata = mem_word(w_addr);
  endtask

  task automatic wait_valid(input bit use_wrap, input int maxc, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if ((use_wrap ? w_valid : if_valid) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: no if_valid within %0d cycles (required within bound)", nm, maxc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: tracks whether a bus request is outstanding, whether
  // its data is to be thrown away, and whether an instruction is held for
  // decode. Updated from the inputs seen at each rising edge.
  // ---------------------------------------------------------------------------
  logic        m_req = 1'b0;
  logic        m_stale = 1'b0;
  logic        m_hold = 1'b0;
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_ipc = 16'h0000;
  logic [15:0] m_instr = 16'h0000;

  always @(posedge clk) begin
    logic        redir;
    logic [15:0] tgt;
    redir = jump_en | branch_taken;
    tgt   = jump_en ? jump_target : PCPlusImm;
    if (!reset_n) begin
      m_req = 1'b0; m_stale = 1'b0; m_hold = 1'b0;
      m_pc = 16'h0000; m_ipc = 16'h0000; m_instr = 16'h0000;
    end else if (m_req) begin
      if (imem_ack) begin
        if (m_stale || redir) begin
          m_stale = 1'b0;
          if (redir) m_pc = tgt;
        end else begin
          m_instr = imem_rdata;
          m_ipc   = m_pc;
          m_pc    = m_pc + 16'd1;
          m_req   = 1'b0;
          m_hold  = 1'b1;
        end
      end else if (redir) begin
        m_pc    = tgt;
        m_stale = 1'b1;
      end
    end else if (m_hold) begin
      if (redir) begin
        m_pc = tgt; m_hold = 1'b0; m_req = 1'b1;
      end else if (id_ready) begin
        m_hold = 1'b0; m_req = 1'b1;
      end
    end else begin
      m_req = 1'b1;
      if (redir) m_pc = tgt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk1 ("mdl_imem_req",  imem_req,  m_req);
      chk16("mdl_imem_addr", imem_addr, m_pc);
      chk1 ("mdl_if_valid",  if_valid,  m_hold);
      chk16("mdl_if_pc",     if_pc,     m_ipc);
      chk16("mdl_if_instr",  if_instr,  m_instr);
    end
  end

  int last_cyc;

  initial begin
    // reset state
    tick();
    chk_en = 1'b1;
    tick();
    chk1 ("rst_req",   imem_req,  1'b0);
    chk16("rst_addr",  imem_addr, 16'h0000);
    chk1 ("rst_valid", if_valid,  1'b0);
    chk16("rst_instr", if_instr,  16'h0000);
    chk16("rst_pc",    if_pc,     16'h0000);
    chk16("w_rst_pc",   w_pc,   16'hFFFF);
    chk16("w_rst_addr", w_addr, 16'hFFFF);
    chk1 ("w_rst_valid", w_valid, 1'b0);

    // four sequential fetches, single-cycle memory, decode always ready
    lat = 0;
    id_ready = 1'b1;
    reset_n = 1'b1;
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_valid(1'b0, 10, "seq_wait");
      chk16("seq_pc",    if_pc,    16'(k));
      chk16("seq_instr", if_instr, mem_word(16'(k)));
      if (k > 0) chk16("seq_gap", 16'(cyc - last_cyc), 16'd2);
      last_cyc = cyc;
      if (k == 3) id_ready = 1'b0;
    end

    // decode stall: outputs hold, no request
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1 ("hold_valid", if_valid,  1'b1);
      chk16("hold_pc",    if_pc,     16'd3);
      chk16("hold_instr", if_instr,  mem_word(16'd3));
      chk1 ("hold_req",   imem_req,  1'b0);
      chk16("hold_addr",  imem_addr, 16'd4);
    end

    // branch while VALID squashes the instruction
    id_ready = 1'b1;
    branch_taken = 1'b1;
    PCPlusImm = 16'h0040;
    tick();
    branch_taken = 1'b0;
    chk1 ("sq_valid", if_valid,  1'b0);
    chk16("sq_addr",  imem_addr, 16'h0040);
    chk1 ("sq_req",   imem_req,  1'b1);
    wait_valid(1'b0, 10, "br_wait");
    chk16("br_pc",    if_pc,    16'h0040);
    chk16("br_instr", if_instr, mem_word(16'h0040));

    // branch while a slow request is pending, then jump+branch together
    lat = 3;
    tick();
    branch_taken = 1'b1;
    PCPlusImm = 16'h0080;
    tick();
    chk16("dis_addr",  imem_addr, 16'h0080);
    chk1 ("dis_req",   imem_req,  1'b1);
    chk1 ("dis_valid", if_valid,  1'b0);
    jump_en = 1'b1;
    jump_target = 16'h0123;
    PCPlusImm = 16'h0090;
    tick();
    jump_en = 1'b0;
    branch_taken = 1'b0;
    chk16("jmp_addr", imem_addr, 16'h0123);
    chk1 ("jmp_req",  imem_req,  1'b1);
    tick();
    chk1 ("dis_ack_valid", if_valid, 1'b0);
    tick();
    chk1 ("reiss_req",   imem_req,  1'b1);
    chk16("reiss_addr",  imem_addr, 16'h0123);
    chk1 ("reiss_valid", if_valid,  1'b0);
    wait_valid(1'b0, 12, "jmp_wait");
    chk16("jmp_pc",    if_pc,    16'h0123);
    chk16("jmp_instr", if_instr, mem_word(16'h0123));

    // reset while a request is pending; a late ack lands in IDLE
    tick();
    chk1("pend_req", imem_req, 1'b1);
    reset_n = 1'b0;
    tick();
    chk1 ("mrst_req",   imem_req,  1'b0);
    chk1 ("mrst_valid", if_valid,  1'b0);
    chk16("mrst_addr",  imem_addr, 16'h0000);
    chk16("mrst_pc",    if_pc,     16'h0000);
    reset_n = 1'b1;
    lat = 0;
    imem_ack = 1'b1;
    imem_rdata = 16'hDEAD;
    tick();
    chk1 ("late_valid", if_valid,  1'b0);
    chk1 ("late_req",   imem_req,  1'b1);
    chk16("late_addr",  imem_addr, 16'h0000);
    chk16("late_instr", if_instr,  16'h0000);
    tick();
    chk1 ("restart_valid", if_valid, 1'b1);
    chk16("restart_pc",    if_pc,    16'h0000);
    chk16("restart_instr", if_instr, mem_word(16'h0000));

    // PC wrap on the second instance
    w_rst_n = 1'b1;
    wait_valid(1'b1, 10, "wrap_wait0");
    chk16("wrap_pc0",    w_pc,    16'hFFFF);
    chk16("wrap_instr0", w_instr, mem_word(16'hFFFF));
    chk16("wrap_addr",   w_addr,  16'h0000);
    wait_valid(1'b1, 10, "wrap_wait1");
    chk16("wrap_pc1",    w_pc,    16'h0000);
    chk16("wrap_instr1", w_instr, mem_word(16'h0000));

    // randomized traffic against the model
    rnd = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      id_ready     = ($urandom_range(0, 3) != 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      PCPlusImm    = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      jump_en      = ($urandom_range(0, 15) == 0);
      jump_target  = 16'($urandom);
      reset_n      = ($urandom_range(0, 199) != 0);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
